// File: rtl/dmem_wb_pkg.sv
// Shared types and constants for the dmem-to-Wishbone master.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Holds the command/width/response encodings seen on the core port, the FSM
// state codes, the base byte-select patterns, and the alignment check used to
// decide whether a request may start a bus cycle.
package dmem_wb_pkg;

  typedef enum logic {
    CMD_READ  = 1'b0,
    CMD_WRITE = 1'b1
  } cmd_e;

  typedef enum logic [1:0] {
    W_BYTE    = 2'd0,
    W_HALF    = 2'd1,
    W_WORD    = 2'd2,
    W_INVALID = 2'd3
  } width_e;

  typedef enum logic [1:0] {
    RESP_NOTRDY = 2'd0,
    RESP_OK     = 2'd1,
    RESP_ERROR  = 2'd2
  } resp_e;

  // FSM state codes kept as plain constants so the state register stays a
  // bare logic vector.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_BUS      = 2'd1;
  localparam logic [1:0] ST_RESP_ERR = 2'd2;

  // Byte-select patterns for lane 0; shifted left by the byte offset.
  localparam logic [3:0] SEL_BYTE = 4'b0001;
  localparam logic [3:0] SEL_HALF = 4'b0011;
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // A request is refused (error response, no bus cycle) when the access would
  // straddle a natural boundary or the width code is the reserved one.
  function automatic logic req_is_bad(input logic [1:0] width,
                                      input logic [1:0] off);
    logic bad;
    case (width)
      W_BYTE:  bad = 1'b0;
      W_HALF:  bad = off[0];
      W_WORD:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_wb_lane_align.sv
// Byte-lane steering for writes and right-justification for reads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   wr_width/wr_off/wr_data -> wr_sel/wr_lanes : write-side select and data
//                                                 replicated across lanes.
//   rd_width/rd_off/rd_bus  -> rd_data         : read-side extraction,
//                                                 masked and zero-extended.
module dmem_wb_lane_align
  import dmem_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            wr_width,
  input  logic [1:0]            wr_off,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [3:0]            wr_sel,
  output logic [DATA_WIDTH-1:0] wr_lanes,
  input  logic [1:0]            rd_width,
  input  logic [1:0]            rd_off,
  input  logic [DATA_WIDTH-1:0] rd_bus,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] rd_shifted;

  // Writes: the slave only latches lanes whose select bit is set, so the
  // payload is simply replicated into every lane instead of being shifted.
  always_comb begin
    wr_sel   = SEL_WORD;
    wr_lanes = wr_data;
    case (wr_width)
      W_BYTE: begin
        wr_sel   = SEL_BYTE << wr_off;
        wr_lanes = {(DATA_WIDTH/8){wr_data[7:0]}};
      end
      W_HALF: begin
        wr_sel   = SEL_HALF << wr_off;
        wr_lanes = {(DATA_WIDTH/16){wr_data[15:0]}};
      end
      default: begin
        wr_sel   = SEL_WORD;
        wr_lanes = wr_data;
      end
    endcase
  end

  // Reads: move the addressed lane down to bit 0, then clear everything
  // above the access width.
  assign rd_shifted = rd_bus >> {rd_off, 3'b000};

  always_comb begin
    rd_data = rd_shifted;
    case (rd_width)
      W_BYTE:  rd_data = {{(DATA_WIDTH-8){1'b0}}, rd_shifted[7:0]};
      W_HALF:  rd_data = {{(DATA_WIDTH-16){1'b0}}, rd_shifted[15:0]};
      default: rd_data = rd_shifted;
    endcase
  end

endmodule

// File: rtl/dmem_wb_master.sv
// Bridges the core data-memory port to a Wishbone classic single-transfer master.
// Latency: accept edge to response is 1 + slave wait states (2 cycles vs a 1-wait RAM); errors respond 1 cycle after accept.
// Backpressure: dmem_req_ack_o is high only in IDLE; the bus side waits on wb_ack_i (or the watchdog when enabled).
//
// Optional feature macro: DMEM_WB_MASTER_TIMEOUT_EN -- when defined, a watchdog
// ends a bus cycle that sees no wb_ack_i within TIMEOUT_CYCLES and returns ERROR.
//
// Ports:
//   wb_clk_i, wb_rst_n_i             clock, asynchronous active-low reset
//   dmem_req_i/cmd/width/addr/wdata  core request (sampled only when accepted)
//   dmem_req_ack_o                   combinational accept
//   dmem_resp_o, dmem_rdata_o        one-cycle response code, held read data
//   wb_adr_o/dat_o/sel_o/we_o        registered Wishbone request fields
//   wb_cyc_o, wb_stb_o               registered cycle/strobe
//   wb_dat_i, wb_ack_i               Wishbone slave return path
module dmem_wb_master
  import dmem_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_cmd_i,
  input  logic [1:0]            dmem_width_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic                  dmem_req_ack_o,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic [1:0]            dmem_resp_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  logic [1:0]            state;
  logic [1:0]            rd_off;
  logic [1:0]            rd_width;
  logic                  req_bad;
  logic [3:0]            lane_sel;
  logic [DATA_WIDTH-1:0] lane_wdat;
  logic [DATA_WIDTH-1:0] lane_rdat;
  logic                  to_hit;

  assign dmem_req_ack_o = dmem_req_i & (state == ST_IDLE);
  assign req_bad        = req_is_bad(dmem_width_i, dmem_addr_i[1:0]);

  // Write steering works on the live request; read extraction works on the
  // offset/width captured at accept, since core inputs are don't-care later.
  dmem_wb_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .wr_width (dmem_width_i),
    .wr_off   (dmem_addr_i[1:0]),
    .wr_data  (dmem_wdata_i),
    .wr_sel   (lane_sel),
    .wr_lanes (lane_wdat),
    .rd_width (rd_width),
    .rd_off   (rd_off),
    .rd_bus   (wb_dat_i),
    .rd_data  (lane_rdat)
  );

`ifdef DMEM_WB_MASTER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;

  // The counter sits at zero outside BUS, so every bus cycle starts fresh.
  // It fires on the edge that would make the TIMEOUT_CYCLES-th cycle
  // without ack, so ERROR appears TIMEOUT_CYCLES cycles after stb rises.
  assign to_hit = (state == ST_BUS) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      to_cnt <= '0;
    end else if (state != ST_BUS) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state        <= ST_IDLE;
      rd_off       <= 2'b00;
      rd_width     <= 2'b00;
      dmem_rdata_o <= '0;
      dmem_resp_o  <= RESP_NOTRDY;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= 4'b0000;
      wb_we_o      <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
    end else begin
      // Response code is a one-cycle pulse; rdata holds until overwritten.
      dmem_resp_o <= RESP_NOTRDY;
      case (state)
        ST_IDLE: begin
          if (dmem_req_i) begin
            if (req_bad) begin
              state <= ST_RESP_ERR;
            end else begin
              wb_adr_o <= {dmem_addr_i[ADDR_WIDTH-1:2], 2'b00};
              wb_dat_o <= lane_wdat;
              wb_sel_o <= lane_sel;
              wb_we_o  <= dmem_cmd_i;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              rd_off   <= dmem_addr_i[1:0];
              rd_width <= dmem_width_i;
              state    <= ST_BUS;
            end
          end
        end

        ST_BUS: begin
          // Request fields stay untouched here so they are stable until ack.
          // An ack on the same edge as a watchdog expiry completes normally.
          if (wb_ack_i) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            dmem_resp_o  <= RESP_OK;
            dmem_rdata_o <= wb_we_o ? '0 : lane_rdat;
            state        <= ST_IDLE;
          end else if (to_hit) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            dmem_resp_o  <= RESP_ERROR;
            dmem_rdata_o <= '0;
            state        <= ST_IDLE;
          end
        end

        ST_RESP_ERR: begin
          dmem_resp_o  <= RESP_ERROR;
          dmem_rdata_o <= '0;
          state        <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wb_master.sv
// Directed bench for dmem_wb_master against a small 1-wait-state Wishbone RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_wb_master;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        cmd;
  logic [1:0]  width;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ack;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  int n_cmp;
  int n_bad;

  // RAM model: acks one cycle after seeing stb, ack_en=0 models a dead slave.
  logic        ack_en;
  logic [31:0] mem [0:255];

  dmem_wb_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (rst_n),
    .dmem_req_i     (req),
    .dmem_cmd_i     (cmd),
    .dmem_width_i   (width),
    .dmem_addr_i    (addr),
    .dmem_wdata_i   (wdata),
    .dmem_req_ack_o (req_ack),
    .dmem_rdata_o   (rdata),
    .dmem_resp_o    (resp),
    .wb_adr_o       (wb_adr),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel),
    .wb_we_o        (wb_we),
    .wb_cyc_o       (wb_cyc),
    .wb_stb_o       (wb_stb),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_i <= '0;
    end else if (wb_cyc && wb_stb && !wb_ack && ack_en) begin
      wb_ack <= 1'b1;
      if (!wb_we) wb_dat_i <= mem[wb_adr[9:2]];
    end else begin
      wb_ack <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && wb_cyc && wb_stb && !wb_ack && ack_en && wb_we) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel[b]) mem[wb_adr[9:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
    end
  end

  // Results of the most recent transfer.
  logic [1:0]  x_resp;
  logic [31:0] x_rdata;
  int          x_lat;
  logic        x_cyc;
  logic        x_ack;
  logic [3:0]  x_sel;
  logic [31:0] x_dat;
  logic [31:0] x_adr;
  logic        x_we;

  // Presents one request, then watches up to 40 cycles for the response.
  // x_lat counts cycles from the accept edge (0 = cycle right after it).
  task automatic xfer(input logic c, input logic [1:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; cmd = c; width = w; addr = a; wdata = d;
    #1 x_ack = req_ack;
    @(posedge clk);
    #1;
    req = 1'b0; cmd = 1'b0; width = 2'd0; addr = '0; wdata = '0;
    x_resp = 2'd0; x_rdata = '0; x_lat = -1; x_cyc = 1'b0;
    x_sel = '0; x_dat = '0; x_adr = '0; x_we = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin
        x_sel = wb_sel; x_dat = wb_dat_o; x_adr = wb_adr; x_we = wb_we;
      end
      if (wb_cyc) x_cyc = 1'b1;
      if (resp != 2'd0) begin
        x_resp = resp; x_rdata = rdata; x_lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b want 000", {wb_cyc, wb_stb, wb_we}); end
    n_cmp++; if (resp !== 2'd0) begin n_bad++; $display("FAIL reset_resp: got %0d want 0", resp); end
    n_cmp++; if ({wb_adr, wb_dat_o, rdata, wb_sel} !== 100'd0) begin n_bad++; $display("FAIL reset_data: adr %h dat %h rdata %h sel %b want all 0", wb_adr, wb_dat_o, rdata, wb_sel); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req_ack, resp, wb_cyc} !== 4'b0000) begin n_bad++; $display("FAIL post_reset_idle: got %b want 0000", {req_ack, resp, wb_cyc}); end
  endtask

  task automatic test_word_rw;
    xfer(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    n_cmp++; if (x_ack !== 1'b1) begin n_bad++; $display("FAIL wr_accept: got %b want 1", x_ack); end
    n_cmp++; if (x_sel !== 4'hF) begin n_bad++; $display("FAIL wr_sel: got %b want 1111", x_sel); end
    n_cmp++; if ({x_we, x_adr, x_dat} !== {1'b1, 32'h100, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wr_bus: we %b adr %h dat %h want 1 100 deadbeef", x_we, x_adr, x_dat); end
    n_cmp++; if ({x_resp, x_rdata} !== {2'd1, 32'h0}) begin n_bad++; $display("FAIL wr_resp: resp %0d rdata %h want 1 0", x_resp, x_rdata); end
    n_cmp++; if (x_lat !== 2) begin n_bad++; $display("FAIL wr_latency: got %0d want 2", x_lat); end
    n_cmp++; if ({wb_cyc, wb_stb} !== 2'b00) begin n_bad++; $display("FAIL wr_cyc_drop: got %b want 00", {wb_cyc, wb_stb}); end
    xfer(1'b0, 2'd2, 32'h100, 32'h0);
    n_cmp++; if ({x_we, x_adr} !== {1'b0, 32'h100}) begin n_bad++; $display("FAIL rd_bus: we %b adr %h want 0 100", x_we, x_adr); end
    n_cmp++; if ({x_resp, x_rdata} !== {2'd1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rd_word: resp %0d rdata %h want 1 deadbeef", x_resp, x_rdata); end
    n_cmp++; if (x_lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", x_lat); end
    // rdata holds after the response pulse.
    @(negedge clk);
    n_cmp++; if ({resp, rdata} !== {2'd0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rd_hold: resp %0d rdata %h want 0 deadbeef", resp, rdata); end
  endtask

  task automatic test_byte_lane;
    xfer(1'b1, 2'd0, 32'h103, 32'hFFFFFFA5);
    n_cmp++; if ({x_sel, x_dat, x_adr} !== {4'b1000, 32'hA5A5A5A5, 32'h100}) begin n_bad++; $display("FAIL byte_wr_bus: sel %b dat %h adr %h want 1000 a5a5a5a5 100", x_sel, x_dat, x_adr); end
    n_cmp++; if ({x_resp, x_rdata} !== {2'd1, 32'h0}) begin n_bad++; $display("FAIL byte_wr_resp: resp %0d rdata %h want 1 0", x_resp, x_rdata); end
    xfer(1'b0, 2'd2, 32'h100, 32'h0);
    n_cmp++; if (x_rdata !== 32'hA5ADBEEF) begin n_bad++; $display("FAIL byte_merge: got %h want a5adbeef", x_rdata); end
  endtask

  task automatic test_subword;
    xfer(1'b1, 2'd2, 32'h100, 32'h12345678);
    xfer(1'b0, 2'd1, 32'h102, 32'h0);
    n_cmp++; if ({x_resp, x_rdata} !== {2'd1, 32'h00001234}) begin n_bad++; $display("FAIL half_rd_102: resp %0d rdata %h want 1 00001234", x_resp, x_rdata); end
    xfer(1'b0, 2'd0, 32'h101, 32'h0);
    n_cmp++; if ({x_resp, x_rdata} !== {2'd1, 32'h00000056}) begin n_bad++; $display("FAIL byte_rd_101: resp %0d rdata %h want 1 00000056", x_resp, x_rdata); end
    xfer(1'b0, 2'd0, 32'h100, 32'h0);
    n_cmp++; if (x_rdata !== 32'h00000078) begin n_bad++; $display("FAIL byte_rd_100: got %h want 00000078", x_rdata); end
    xfer(1'b1, 2'd1, 32'h102, 32'h0000BEEF);
    n_cmp++; if ({x_sel, x_dat} !== {4'b1100, 32'hBEEFBEEF}) begin n_bad++; $display("FAIL half_wr_bus: sel %b dat %h want 1100 beefbeef", x_sel, x_dat); end
    xfer(1'b0, 2'd2, 32'h100, 32'h0);
    n_cmp++; if (x_rdata !== 32'hBEEF5678) begin n_bad++; $display("FAIL half_merge: got %h want beef5678", x_rdata); end
  endtask

  task automatic test_errors;
    logic [1:0]  ew [3];
    logic [31:0] ea [3];
    ew[0] = 2'd2; ea[0] = 32'h102;
    ew[1] = 2'd1; ea[1] = 32'h101;
    ew[2] = 2'd3; ea[2] = 32'h100;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, ew[i], ea[i], 32'hCAFEF00D);
      n_cmp++; if (x_ack !== 1'b1) begin n_bad++; $display("FAIL err_accept[%0d]: got %b want 1", i, x_ack); end
      n_cmp++; if ({x_resp, x_rdata} !== {2'd2, 32'h0}) begin n_bad++; $display("FAIL err_resp[%0d]: resp %0d rdata %h want 2 0", i, x_resp, x_rdata); end
      n_cmp++; if (x_lat !== 1) begin n_bad++; $display("FAIL err_latency[%0d]: got %0d want 1", i, x_lat); end
      n_cmp++; if (x_cyc !== 1'b0) begin n_bad++; $display("FAIL err_no_cyc[%0d]: got %b want 0", i, x_cyc); end
    end
    // The refused write must not have touched memory.
    xfer(1'b0, 2'd2, 32'h100, 32'h0);
    n_cmp++; if (x_rdata !== 32'hBEEF5678) begin n_bad++; $display("FAIL err_no_write: got %h want beef5678", x_rdata); end
  endtask

  task automatic test_back_to_back;
    int n_ok;
    n_ok = 0;
    @(negedge clk);
    req = 1'b1; cmd = 1'b0; width = 2'd2; addr = 32'h100;
    // Cycles after accept edges: responses land in cycles 3, 6 and 9.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (resp == 2'd1) begin
        n_ok++;
        n_cmp++; if ({req_ack, wb_stb, rdata} !== {1'b1, 1'b0, 32'hBEEF5678}) begin n_bad++; $display("FAIL b2b_resp_cycle[%0d]: ack %b stb %b rdata %h want 1 0 beef5678", k, req_ack, wb_stb, rdata); end
      end
      n_cmp++; if ((resp == 2'd1) !== (k % 3 == 0)) begin n_bad++; $display("FAIL b2b_timing[%0d]: resp %0d want ok=%0d", k, resp, (k % 3 == 0)); end
    end
    req = 1'b0;
    n_cmp++; if (n_ok !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", n_ok); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_bus;
    @(negedge clk);
    req = 1'b1; cmd = 1'b0; width = 2'd2; addr = 32'h100;
    @(posedge clk);
    #1 req = 1'b0;
    n_cmp++; if (wb_stb !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stb: got %b want 1", wb_stb); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({wb_cyc, wb_stb} !== 2'b00) begin n_bad++; $display("FAIL rst_async_drop: got %b want 00", {wb_cyc, wb_stb}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if ({resp, wb_cyc} !== 3'b000) begin n_bad++; $display("FAIL rst_no_resp[%0d]: resp %0d cyc %b want 0 0", k, resp, wb_cyc); end
    end
    xfer(1'b0, 2'd2, 32'h100, 32'h0);
    n_cmp++; if ({x_resp, x_rdata, x_lat} !== {2'd1, 32'hBEEF5678, 32'd2}) begin n_bad++; $display("FAIL rst_recover: resp %0d rdata %h lat %0d want 1 beef5678 2", x_resp, x_rdata, x_lat); end
  endtask

`ifdef DMEM_WB_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    ack_en = 1'b0;
    xfer(1'b0, 2'd2, 32'h100, 32'h0);
    n_cmp++; if ({x_resp, x_rdata} !== {2'd2, 32'h0}) begin n_bad++; $display("FAIL to_resp: resp %0d rdata %h want 2 0", x_resp, x_rdata); end
    n_cmp++; if (x_lat !== 8) begin n_bad++; $display("FAIL to_latency: got %0d want 8", x_lat); end
    n_cmp++; if ({wb_cyc, wb_stb} !== 2'b00) begin n_bad++; $display("FAIL to_cyc_drop: got %b want 00", {wb_cyc, wb_stb}); end
    ack_en = 1'b1;
    xfer(1'b0, 2'd2, 32'h100, 32'h0);
    n_cmp++; if ({x_resp, x_lat} !== {2'd1, 32'd2}) begin n_bad++; $display("FAIL to_recover: resp %0d lat %0d want 1 2", x_resp, x_lat); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; ack_en = 1'b1;
    req = 1'b0; cmd = 1'b0; width = 2'd0; addr = '0; wdata = '0;
    test_reset();
    test_word_rw();
    test_byte_lane();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_mid_bus();
`ifdef DMEM_WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
